// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter among NUM_REQ
// requesters. The UART has no done flag, so each frame occupies a fixed
// slot of SLOT clocks counted locally from the UART's baud parameters.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_SIZE   = 7,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 960000,
    parameter int GUARD_BITS  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         tx_start,
    output logic [DATA_SIZE-1:0]         tx_data,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   owner
);

    localparam int CPB  = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE;
    localparam int SLOT = (DATA_SIZE + 2 + GUARD_BITS) * CPB;
    localparam int OW   = $clog2(NUM_REQ);
    localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;

    localparam logic [OW-1:0]      LAST_REQ = OW'(NUM_REQ - 1);
    localparam logic [CW-1:0]      LAST_CNT = CW'(SLOT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    if (CPB < 1 || NUM_REQ < 2) begin : g_bad_params
        $error("uart_tx_arbiter: CPB must be >= 1 and NUM_REQ >= 2");
    end

    typedef enum logic {IDLE, SLOT_ST} state_t;

    state_t          state;
    logic [OW-1:0]   rr_ptr;
    logic [CW-1:0]   cnt;
    logic [OW-1:0]   win;
    logic            found;

    // Winner: first set req bit scanning upward from rr_ptr with wrap.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = OW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Grant/slot FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            owner    <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        ack      <= ONE_HOT0 << win;
                        tx_start <= 1'b1;
                        tx_data  <= req_data[int'(win)*DATA_SIZE +: DATA_SIZE];
                        owner    <= win;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        state    <= SLOT_ST;
                    end
                end
                SLOT_ST: begin
                    // Slot ends after SLOT busy cycles; pointer moves past owner.
                    if (cnt == LAST_CNT) begin
                        busy   <= 1'b0;
                        rr_ptr <= (owner == LAST_REQ) ? '0 : owner + 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued when
// requests are driven and checked as each tx_start appears.
module tb_uart_tx_arbiter;

    localparam int NR   = 4;
    localparam int DS   = 7;
    localparam int SLOT = 520;

    logic               clk = 1'b0;
    logic               reset;
    logic [NR-1:0]      req;
    logic [NR*DS-1:0]   req_data;
    logic [NR-1:0]      ack;
    logic               tx_start;
    logic [DS-1:0]      tx_data;
    logic               busy;
    logic [1:0]         owner;

    uart_tx_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [DS-1:0] data;
        int          gap;   // required cycles since previous tx_start, 0 = unchecked
    } exp_t;

    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_start = 0;
    int busy_cnt = 0;
    int unstable = 0;
    bit prev_busy = 0;
    bit skip_busy = 0;
    bit auto_drop = 1;
    logic [DS-1:0] latched = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int idx, input logic [DS-1:0] d, input int gap);
        exp_t e;
        e.idx = idx; e.data = d; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic set_data(input int i, input logic [DS-1:0] v);
        req_data[i*DS +: DS] = v;
    endtask

    // Advance one cycle, observe outputs at negedge, then model requesters.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (tx_start) begin
            if (q.size() == 0) begin
                chk("unexpected_start", 32'(tx_start), 0);
            end else begin
                e = q.pop_front();
                chk("ack", 32'(ack), 32'(1 << e.idx));
                chk("owner", 32'(owner), 32'(e.idx));
                chk("tx_data", 32'(tx_data), 32'(e.data));
                chk("busy_at_start", 32'(busy), 1);
                if (e.gap != 0) chk("start_gap", 32'(cyc - last_start), 32'(e.gap));
            end
            last_start = cyc;
            latched    = tx_data;
            busy_cnt   = 0;
            unstable   = 0;
        end else if (ack != '0) begin
            chk("ack_without_start", 32'(ack), 0);
        end
        if (busy) begin
            busy_cnt++;
            if (tx_data !== latched) unstable++;
        end
        if (!busy && prev_busy && !skip_busy) begin
            chk("busy_len", 32'(busy_cnt), SLOT);
            chk("data_stable", 32'(unstable), 0);
        end
        prev_busy = busy;
        if (auto_drop) req = req & ~ack;
    endtask

    task automatic do_reset();
        skip_busy = 1;
        reset = 1'b1;
        req   = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        skip_busy = 0;
        q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain", 32'(q.size()) + 32'(busy), 0);
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_data = '0;

        // Reset state
        do_reset();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);

        // Single request from requester 1
        set_data(1, 7'h57);
        req = 4'b0010;
        push(1, 7'h57, 0);
        tick();
        chk("single_latency", 32'(tx_start), 1);
        tick();
        chk("single_pulse_len", 32'(tx_start), 0);
        wait_idle(SLOT + 20);

        // All four at once, grants 0..3 spaced SLOT+1
        do_reset();
        set_data(0, 7'h11); set_data(1, 7'h22);
        set_data(2, 7'h33); set_data(3, 7'h44);
        req = 4'b1111;
        push(0, 7'h11, 0);
        push(1, 7'h22, SLOT + 1);
        push(2, 7'h33, SLOT + 1);
        push(3, 7'h44, SLOT + 1);
        wait_idle(4 * (SLOT + 1) + 20);

        // Wrap-around: serve 2 so rr_ptr=3, then 3 before 0
        do_reset();
        set_data(2, 7'h5A);
        req = 4'b0100;
        push(2, 7'h5A, 0);
        wait_idle(SLOT + 20);
        set_data(0, 7'h0F); set_data(3, 7'h70);
        req = 4'b1001;
        push(3, 7'h70, 0);
        push(0, 7'h0F, SLOT + 1);
        wait_idle(2 * (SLOT + 1) + 20);

        // Withdrawal: req[1] pulsed while busy must not be served
        set_data(0, 7'h2D); set_data(1, 7'h66);
        req = 4'b0001;
        push(0, 7'h2D, 0);
        repeat (50) tick();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        wait_idle(SLOT + 20);
        repeat (20) tick();
        chk("withdraw_busy", 32'(busy), 0);

        // Reset 200 cycles into a slot
        do_reset();
        set_data(0, 7'h3C);
        req = 4'b0001;
        push(0, 7'h3C, 0);
        tick();
        chk("pre_abort_start", 32'(tx_start), 1);
        repeat (199) tick();
        chk("pre_abort_busy", 32'(busy), 1);
        skip_busy = 1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_tx_data", 32'(tx_data), 0);
        chk("abort_owner", 32'(owner), 0);
        tick();
        skip_busy = 0;
        set_data(2, 7'h4B);
        req = 4'b0100;
        push(2, 7'h4B, 0);
        tick();
        chk("post_abort_latency", 32'(tx_start), 1);
        wait_idle(SLOT + 20);

        // Persistent req[0]: retransmit every SLOT+1 cycles
        auto_drop = 0;
        set_data(0, 7'h61);
        req = 4'b0001;
        push(0, 7'h61, 0);
        push(0, 7'h61, SLOT + 1);
        push(0, 7'h61, SLOT + 1);
        begin
            int n = 0;
            while (q.size() != 0 && n < 3 * (SLOT + 1) + 20) begin
                tick();
                n++;
            end
        end
        req = 4'b0000;
        auto_drop = 1;
        wait_idle(SLOT + 20);
        repeat (10) tick();
        chk("final_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
